// File: rtl/pc_redirect_unit_if.sv
// Control and address bundle between the ID/EX stages and the fetch redirect unit.
// Latency: none (wires only).
// Backpressure: stall travels in on this bundle; the unit has no ready/credit return path.
//
// Ports (grouped):
//   requests  : stall, jal, jalr, B_JUMP, offset, imm_ID, pc_ID, pc_EX
//   fetch     : pc_IF, if_valid
//   squash    : flush_IF_ID, flush_ID_EX
//   exception : misalign_exc, exc_pc
//   perf      : redirect_cnt
interface pc_redirect_unit_if #(
  parameter int CNT_W = 16
);
  // Requests from the decode/execute stages
  logic             stall;
  logic             jal;
  logic             jalr;
  logic             B_JUMP;
  logic [31:0]      offset;
  logic [31:0]      imm_ID;
  logic [31:0]      pc_ID;
  logic [31:0]      pc_EX;

  // Results toward fetch, pipeline registers and trap logic
  logic [31:0]      pc_IF;
  logic             if_valid;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             misalign_exc;
  logic [31:0]      exc_pc;
  logic [CNT_W-1:0] redirect_cnt;

  // Pipeline side: drives requests, observes results
  modport master (
    output stall, jal, jalr, B_JUMP, offset, imm_ID, pc_ID, pc_EX,
    input  pc_IF, if_valid, flush_IF_ID, flush_ID_EX, misalign_exc, exc_pc, redirect_cnt
  );

  // Redirect unit side
  modport slave (
    input  stall, jal, jalr, B_JUMP, offset, imm_ID, pc_ID, pc_EX,
    output pc_IF, if_valid, flush_IF_ID, flush_ID_EX, misalign_exc, exc_pc, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: picks branch/jal/jalr targets, traps misaligned ones, issues flushes and fetch bubbles.
// Latency: decision in cycle N -> pc_IF updated in N+1; if_valid low in N+1, high again in N+2.
// Backpressure: stall holds pc_IF and defers ID jumps; an EX branch overrides stall.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pc_redirect_unit_if.slave (requests in; pc_IF, if_valid, flushes, exception, counter out)
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_redirect_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  state_t           state_q;
  state_t           state_d;
  logic             exc_q;
  logic [31:0]      exc_pc_q;
  logic [CNT_W-1:0] cnt_q;

  // ------------------------------------------------------------------
  // Decision
  // ------------------------------------------------------------------
  logic        br;
  logic        jp;
  logic        redirect;
  logic [31:0] base;
  logic [31:0] sum;
  logic [31:0] target;
  logic        misalign;

  // An EX branch means the ID instruction is on the wrong path, so its
  // jump is dropped. A stalled ID jump simply waits and re-evaluates.
  assign br       = bus.B_JUMP;
  assign jp       = (bus.jal | bus.jalr) & ~bus.stall & ~bus.B_JUMP;
  assign redirect = br | jp;

  // Single adder: only the base is muxed, since offset is already
  // pre-selected upstream to match the redirect source.
  always_comb begin
    base = bus.imm_ID;
    if (br) begin
      base = bus.pc_EX;
    end else if (bus.jal) begin
      base = bus.pc_ID;
    end
  end

  assign sum = base + bus.offset;

  // jalr clears bit 0 of its computed address; bit 1 can still fault.
  assign target   = (!br && !bus.jal) ? (sum & 32'hFFFF_FFFE) : sum;
  assign misalign = redirect & (target[1:0] != 2'b00);

  // ------------------------------------------------------------------
  // Fetch PC
  // ------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q + 32'd4;            // wraps silently at the top of memory
    if (misalign) begin
      pc_d = TRAP_VEC;
    end else if (redirect) begin
      pc_d = target;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // ------------------------------------------------------------------
  // Fetch-valid FSM
  // ------------------------------------------------------------------
  // BOOT covers the first synchronous imem read, which has no valid
  // address behind it yet. BUBBLE covers the one wrong-path word already
  // in flight when pc_IF is redirected; a redirect while in BUBBLE
  // starts a fresh bubble for the new wrong-path word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.if_valid = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        bus.if_valid = ~bus.stall;
        if (redirect) begin
          state_d = BUBBLE;
        end
      end
      BUBBLE: begin
        // stall does not stretch the bubble: the wrong-path word is
        // exactly one cycle long regardless.
        state_d = redirect ? BUBBLE : RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Flushes
  // ------------------------------------------------------------------
  // A jal/jalr in ID is itself a valid instruction and must continue
  // into EX; only an EX branch squashes ID/EX. Gated by rst_n so no
  // squash escapes while the pipeline is held in reset.
  assign bus.flush_IF_ID = redirect & rst_n;
  assign bus.flush_ID_EX = br & rst_n;

  // ------------------------------------------------------------------
  // Misaligned-target exception
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q    <= 1'b0;
      exc_pc_q <= 32'h0000_0000;
    end else begin
      exc_q <= misalign;
      if (misalign) begin
        exc_pc_q <= br ? bus.pc_EX : bus.pc_ID;
      end
    end
  end

  // ------------------------------------------------------------------
  // Redirect performance counter (saturating)
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.pc_IF        = pc_q;
  assign bus.misalign_exc = exc_q;
  assign bus.exc_pc       = exc_pc_q;
  assign bus.redirect_cnt = cnt_q;

  // ------------------------------------------------------------------
  // Invariants
  // ------------------------------------------------------------------
  a_flush_nesting : assert property (@(posedge clk) disable iff (!rst_n)
    bus.flush_ID_EX |-> bus.flush_IF_ID);

  a_bubble_invalid : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BUBBLE) |-> !bus.if_valid);

  a_misalign_traps : assert property (@(posedge clk) disable iff (!rst_n)
    misalign |=> (pc_q == TRAP_VEC) && exc_q);

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the branch/jump offset path. Takes the selected offset and pairs it with the matching base: pc_EX for a branch, pc_ID for jal, imm_ID for jalr.
- Computes the target address, owns the fetch PC register, and issues pipeline flushes and fetch-valid bubbles.
- Sits at the IF stage, between the ID/EX control signals and the synchronous instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_IF on reset.
- TRAP_VEC, 32'h0000_0100, fetch address on a misaligned-target exception.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- stall  input  1  hazard stall; holds pc_IF and blocks ID-stage jumps.
- jal  input  1  jal in ID.
- jalr  input  1  jalr in ID.
- B_JUMP  input  1  branch resolved taken in EX.
- offset  input  32  selected offset: imm_EX for a branch, read1 for jalr, imm_ID otherwise.
- imm_ID  input  32  ID immediate; base for jalr.
- pc_ID  input  32  PC of the ID instruction.
- pc_EX  input  32  PC of the EX instruction.
- pc_IF  output  32  fetch address to instruction memory.
- if_valid  output  1  instruction memory output this cycle is on the correct path.
- flush_IF_ID  output  1  squash the IF/ID register.
- flush_ID_EX  output  1  squash the ID/EX register.
- misalign_exc  output  1  one-cycle exception pulse.
- exc_pc  output  32  PC of the last faulting instruction.
- redirect_cnt  output  CNT_W  count of taken redirects.

Behaviour:
- Reset (asynchronous, rst_n=0), all outputs:
  - pc_IF=RESET_PC
  - if_valid=0
  - misalign_exc=0
  - exc_pc=0
  - redirect_cnt=0
  - FSM state=BOOT
  - flush_IF_ID and flush_ID_EX read 0 while reset is held.
- Per-cycle decision, evaluated combinationally:
  - br = B_JUMP
  - jp = (jal|jalr) & ~stall & ~B_JUMP
  - redirect = br|jp
- Target computation:
  - br: target = pc_EX + offset.
  - jal: target = pc_ID + offset.
  - jalr: target = (imm_ID + offset) & ~32'h1.
  - All adds are modulo 2^32; wrap-around is silent.
- Misaligned target: misalign = redirect & (target[1:0] != 2'b00).
- pc_IF next-value priority:
  1. misalign → TRAP_VEC
  2. redirect → target
  3. stall → hold
  4. otherwise → pc_IF+4 (0xFFFF_FFFC wraps to 0x0000_0000)
- Flushes (combinational, same cycle as the decision):
  - flush_IF_ID = redirect.
  - flush_ID_EX = br only; a jal/jalr in ID is itself valid and must proceed.
- Simultaneous events:
  - B_JUMP with jal/jalr: the branch wins and the ID jump is discarded, because it is on the wrong path.
  - B_JUMP with stall: the redirect proceeds and stall is ignored for pc_IF.
  - jal/jalr with stall: no redirect; the jump re-evaluates when stall drops.
- FSM, registered, three states:
  - BOOT: if_valid=0; always goes to RUN next cycle, because the first imem read is not yet valid.
  - RUN: if_valid=1 unless stall; on redirect (including misalign) goes to BUBBLE.
  - BUBBLE: if_valid=0 for exactly one cycle, covering the wrong-path word from the synchronous memory.
    - Then RUN, unless another redirect occurs in BUBBLE, in which case stay in BUBBLE.
    - stall in BUBBLE does not extend the bubble.
- Misalign exception:
  - misalign_exc is registered: high for exactly the cycle after the misaligned decision.
  - exc_pc loads pc_EX (branch) or pc_ID (jump) on that edge, and holds otherwise.
- redirect_cnt: increments by 1 on every edge where redirect=1 (misaligned redirects included); saturates at all-ones.
- Reset mid-operation: immediate return to the reset values above; no partial redirect survives.
- Latency summary:
  - Redirect decision in cycle N → pc_IF=target in N+1.
  - if_valid=0 in N+1, 1 in N+2 if no further redirect.

Test Plan:
- Reset release, no stimulus:
  - pc_IF sequence 0x0, 0x4, 0x8, 0xC.
  - if_valid is 0 in the first cycle after release, then 1.
- B_JUMP=1, pc_EX=0x40, offset=0xFFFF_FFF0:
  - pc_IF=0x30 next cycle.
  - flush_IF_ID=flush_ID_EX=1 in the decision cycle.
  - if_valid=0 for one cycle; redirect_cnt=1.
- jalr=1, imm_ID=0x4, offset=0x101:
  - target 0x104 after the bit-0 clear; pc_IF=0x104.
  - flush_IF_ID=1, flush_ID_EX=0.
- Same cycle jal=1 (pc_ID=0x80, offset=0x20) and B_JUMP=1 (pc_EX=0x7C, offset=0x100):
  - pc_IF=0x17C; the jal is ignored; redirect_cnt increments by 1 only.
- jal=1, pc_ID=0x10, offset=0x6:
  - pc_IF=TRAP_VEC=0x100.
  - misalign_exc pulses for 1 cycle; exc_pc=0x10.
- Edge cases:
  - stall=1 with jal=1 for 3 cycles: pc_IF holds and there is no flush; the jump takes effect on the cycle stall drops.
  - pc_IF=0xFFFF_FFFC with no event: wraps to 0x0.
  - rst_n pulsed low mid-BUBBLE: all outputs return to reset values immediately.
